// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU: operands and op in, result and status flags out.
// Both directions use valid/ready handshakes.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             overflow;
    logic             div_zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, hi, zero, overflow, div_zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, hi, zero, overflow, div_zero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/arith/shift ops take 1 cycle, MUL/DIV iterate one bit per cycle (WIDTH+1 latency).
// One operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [4:0] OP_AND = 5'b00000, OP_OR  = 5'b00001, OP_ADD = 5'b00010,
                           OP_SUB = 5'b00011, OP_SLT = 5'b00110, OP_SLTU = 5'b00111,
                           OP_SLL = 5'b01000, OP_SRL = 5'b01001, OP_SRA = 5'b01010,
                           OP_XOR = 5'b01100, OP_NOR = 5'b01101, OP_LUI = 5'b01110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d, a_q, a_d;
    logic             is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dovf_q, dovf_d;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] add_s, sub_s, alu_res;
    logic             alu_ovf;
    logic [WIDTH:0]   mul_sum, rem_sh, diff;
    logic [WIDTH-1:0] step_acc, step_q;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic             sgn, a_neg, b_neg;

    assign sh    = bus.a[SHW-1:0];
    assign add_s = bus.a + bus.b;
    assign sub_s = bus.a - bus.b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_ADD: begin
                alu_res = add_s;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_s;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            OP_SLL:  alu_res = bus.b << sh;
            OP_SRL:  alu_res = bus.b >> sh;
            OP_SRA:  alu_res = $unsigned($signed(bus.b) >>> sh);
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_LUI:  alu_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: alu_res = '0;
        endcase
    end

    // Shift-add multiply on {acc,q}; restoring divide keeps quotient bits in q, remainder in acc.
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
        rem_sh   = {acc_q, q_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, m_q};
        step_acc = mul_sum[WIDTH:1];
        step_q   = {mul_sum[0], q_q[WIDTH-1:1]};
        if (is_div_q) begin
            step_acc = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            step_q   = {q_q[WIDTH-2:0], ~diff[WIDTH]};
        end
        prod     = {step_acc, step_q};
        prod_fix = neg_q ? -prod : prod;
    end

    assign sgn   = ~bus.op[0];
    assign a_neg = sgn & bus.a[WIDTH-1];
    assign b_neg = sgn & bus.b[WIDTH-1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        m_d      = m_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dovf_d   = dovf_q;
        res_d    = res_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                if (bus.op[4:2] == 3'b100) begin
                    // Iterate on magnitudes; signs are restored when the last bit is done.
                    state_d  = BUSY;
                    cnt_d    = CNT_INIT;
                    acc_d    = '0;
                    q_d      = a_neg ? -bus.a : bus.a;
                    m_d      = b_neg ? -bus.b : bus.b;
                    a_d      = bus.a;
                    is_div_d = bus.op[1];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    dovf_d   = sgn & bus.op[1] & (bus.a == MOST_NEG) & (bus.b == '1);
                end else begin
                    state_d = DONE;
                    res_d   = alu_res;
                    hi_d    = '0;
                    zero_d  = (alu_res == '0);
                    ovf_d   = alu_ovf;
                    dz_d    = 1'b0;
                end
            end
            BUSY: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    if (!is_div_q) begin
                        res_d = prod_fix[WIDTH-1:0];
                        hi_d  = prod_fix[2*WIDTH-1:WIDTH];
                    end else if (m_q == '0) begin
                        res_d = '1;
                        hi_d  = a_q;
                        dz_d  = 1'b1;
                    end else begin
                        res_d = neg_q ? -step_q : step_q;
                        hi_d  = rneg_q ? -step_acc : step_acc;
                        ovf_d = dovf_q;
                    end
                    zero_d = (res_d == '0);
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dovf_q   <= 1'b0;
            res_q    <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            m_q      <= m_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dovf_q   <= dovf_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.hi        = hi_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus randomized ops against a 64-bit arithmetic model.
module tb_alu_mc;
    localparam logic [4:0] AND_ = 5'b00000, OR_ = 5'b00001, ADD_ = 5'b00010, SUB_ = 5'b00011,
                           SLT_ = 5'b00110, SLTU_ = 5'b00111, SLL_ = 5'b01000, SRL_ = 5'b01001,
                           SRA_ = 5'b01010, XOR_ = 5'b01100, NOR_ = 5'b01101, LUI_ = 5'b01110,
                           MUL_ = 5'b10000, MULU_ = 5'b10001, DIV_ = 5'b10010, DIVU_ = 5'b10011;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_mc_if #(.WIDTH(32)) bus ();
    alu_mc #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit integer arithmetic, straight from the op definitions.
    function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [31:0] h,
                                      output logic ov, output logic dz, output int lat);
        longint sa, sb, s;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r = '0; h = '0; ov = 1'b0; dz = 1'b0;
        lat = (op inside {MUL_, MULU_, DIV_, DIVU_}) ? 33 : 1;
        case (op)
            AND_:  r = a & b;
            OR_:   r = a | b;
            ADD_:  begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            SUB_:  begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            SLT_:  r = (sa < sb) ? 32'd1 : 32'd0;
            SLTU_: r = (ua < ub) ? 32'd1 : 32'd0;
            SLL_:  r = b << a[4:0];
            SRL_:  r = b >> a[4:0];
            SRA_:  r = $signed(b) >>> a[4:0];
            XOR_:  r = a ^ b;
            NOR_:  r = ~(a | b);
            LUI_:  r = {b[15:0], 16'h0000};
            MUL_:  begin s = sa * sb; r = s[31:0]; h = s[63:32]; end
            MULU_: begin up = ua * ub; r = up[31:0]; h = up[63:32]; end
            DIV_: begin
                if (b == 0) begin r = '1; h = a; dz = 1'b1; end
                else begin
                    s = sa / sb; r = s[31:0];
                    s = sa % sb; h = s[31:0];
                    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
                end
            end
            DIVU_: begin
                if (b == 0) begin r = '1; h = a; dz = 1'b1; end
                else begin up = ua / ub; r = up[31:0]; up = ua % ub; h = up[31:0]; end
            end
            default: r = '0;
        endcase
    endfunction

    // Issues one op, keeps in_valid high with junk operands while waiting, then retires it.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [31:0] h, output logic z,
                         output logic ov, output logic dz, output int lat, output int rdy_hi);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.op = 5'($urandom); bus.a = $urandom; bus.b = $urandom;
        lat = 1; rdy_hi = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_hi++;
            @(negedge clk);
            lat++;
        end
        if (bus.in_ready) rdy_hi++;
        r = bus.result; h = bus.hi; z = bus.zero; ov = bus.overflow; dz = bus.div_zero;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.zero, bus.overflow, bus.div_zero} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {bus.out_valid, bus.zero, bus.overflow, bus.div_zero});
        end
        checks++;
        if ({bus.result, bus.hi} !== 64'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {bus.result, bus.hi});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_add_overflow();
        logic [31:0] r, h; logic z, ov, dz; int lat, rh;
        do_op(ADD_, 32'h7FFF_FFFF, 32'h1, r, h, z, ov, dz, lat, rh);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d exp 1", lat); end
        checks++;
        if ({r, ov, z} !== {32'h8000_0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add_ovf got r=%h ov=%b z=%b exp r=80000000 ov=1 z=0", r, ov, z);
        end
    endtask

    task automatic test_sub_hold();
        int valid_cnt, rdy_cnt;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = SUB_; bus.a = 32'd5; bus.b = 32'd5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        valid_cnt = 0; rdy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.out_valid && bus.result == 0 && bus.zero) valid_cnt++;
            if (bus.in_ready) rdy_cnt++;
            if (k == 3) bus.out_ready = 1'b1;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        checks++;
        if (valid_cnt !== 4) begin errors++; $display("FAIL sub_hold_valid got %0d exp 4", valid_cnt); end
        checks++;
        if (rdy_cnt !== 0) begin errors++; $display("FAIL sub_hold_in_ready got %0d exp 0", rdy_cnt); end
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++; $display("FAIL sub_release got %b exp 01", {bus.out_valid, bus.in_ready});
        end
    endtask

    task automatic test_mul();
        logic [31:0] r, h; logic z, ov, dz; int lat, rh;
        do_op(MUL_, 32'hFFFF_FFFF, 32'd2, r, h, z, ov, dz, lat, rh);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d exp 33", lat); end
        checks++;
        if ({h, r} !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mul_prod got %h exp FFFFFFFFFFFFFFFE", {h, r}); end
        checks++;
        if (rh !== 0) begin errors++; $display("FAIL mul_in_ready_busy got %0d exp 0", rh); end
        do_op(MULU_, 32'hFFFF_FFFF, 32'd2, r, h, z, ov, dz, lat, rh);
        checks++;
        if ({h, r} !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL mulu_prod got %h exp 00000001FFFFFFFE", {h, r}); end
    endtask

    task automatic test_div();
        logic [31:0] r, h; logic z, ov, dz; int lat, rh;
        do_op(DIV_, -32'sd7, 32'd2, r, h, z, ov, dz, lat, rh);
        checks++;
        if ({r, h} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div_neg got r=%h h=%h exp FFFFFFFD FFFFFFFF", r, h); end
        do_op(DIVU_, 32'd7, 32'd0, r, h, z, ov, dz, lat, rh);
        checks++;
        if ({r, h, dz, lat} !== {32'hFFFF_FFFF, 32'd7, 1'b1, 32'd33}) begin
            errors++; $display("FAIL divu_zero got r=%h h=%h dz=%b lat=%0d exp FFFFFFFF 7 1 33", r, h, dz, lat);
        end
        do_op(DIV_, 32'h8000_0000, 32'hFFFF_FFFF, r, h, z, ov, dz, lat, rh);
        checks++;
        if ({r, h, ov, dz} !== {32'h8000_0000, 32'h0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL div_min_neg1 got r=%h h=%h ov=%b dz=%b exp 80000000 0 1 0", r, h, ov, dz);
        end
    endtask

    task automatic test_sra();
        logic [31:0] r, h; logic z, ov, dz; int lat, rh;
        do_op(SRA_, 32'h24, 32'h8000_0000, r, h, z, ov, dz, lat, rh);
        checks++;
        if (r !== 32'hF800_0000) begin errors++; $display("FAIL sra got %h exp F8000000", r); end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] r, h; logic z, ov, dz; int lat, rh, seen;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = DIV_; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++; $display("FAIL abort_in_reset got %b exp 01", {bus.out_valid, bus.in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen !== 0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_no_result got valid_cycles=%0d in_ready=%b exp 0 1", seen, bus.in_ready);
        end
        do_op(AND_, 32'hF0, 32'h3C, r, h, z, ov, dz, lat, rh);
        checks++;
        if (r !== 32'h30) begin errors++; $display("FAIL and_after_abort got %h exp 30", r); end
    endtask

    task automatic test_random();
        logic [4:0] ops [22];
        logic [31:0] specials [6];
        logic [31:0] a, b, r, h, er, eh;
        logic z, ov, dz, eov, edz;
        int lat, elat, rh;
        ops = '{AND_, OR_, ADD_, SUB_, SLT_, SLTU_, SLL_, SRL_, SRA_, XOR_, NOR_, LUI_,
                MUL_, MULU_, DIV_, DIVU_, MUL_, DIV_, 5'b00100, 5'b01011, 5'b10100, 5'b11111};
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3};
        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            op = ops[$urandom_range(0, 21)];
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 31);
            ref_model(op, a, b, er, eh, eov, edz, elat);
            do_op(op, a, b, r, h, z, ov, dz, lat, rh);
            checks++;
            if (r !== er || h !== eh) begin
                errors++; $display("FAIL rand_data op=%b a=%h b=%h got %h:%h exp %h:%h", op, a, b, h, r, eh, er);
            end
            checks++;
            if ({z, ov, dz} !== {(er == 0), eov, edz}) begin
                errors++; $display("FAIL rand_flags op=%b a=%h b=%h got zod=%b%b%b exp %b%b%b", op, a, b, z, ov, dz, (er == 0), eov, edz);
            end
            checks++;
            if (lat !== elat || rh !== 0) begin
                errors++; $display("FAIL rand_timing op=%b got lat=%0d rdy=%0d exp lat=%0d rdy=0", op, lat, rh, elat);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_overflow();
        test_sub_hold();
        test_mul();
        test_div();
        test_sra();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are powers of two, 8 to 64.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  5  operation select.
REQ-008 SHALL have ports a and b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  WIDTH  primary result; low product or quotient for MUL/DIV.
REQ-012 SHALL have port hi  output  WIDTH  high product or remainder; 0 for other ops.
REQ-013 SHALL have ports zero, overflow and div_zero  output  1 each  status flags.

Function
REQ-014 SHALL use these op codes: 00000 AND; 00001 OR; 00010 ADD; 00011 SUB; 00110 SLT (signed); 00111 SLTU; 01000 SLL b<<a; 01001 SRL b>>a; 01010 SRA b>>>a; 01100 XOR; 01101 NOR; 01110 LUI {b[WIDTH/2-1:0], zeros}; 10000 MUL (signed); 10001 MULU; 10010 DIV (signed); 10011 DIVU.
REQ-015 SHALL treat any other op as single-cycle with result 0.
REQ-016 SHALL take the shift amount from a[SHW-1:0] only.
REQ-017 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-018 SHALL drive in_ready=1 only in IDLE.
REQ-019 SHALL treat a handshake as in_valid & in_ready; operands and op are captured at that edge.
REQ-020 SHALL, on a single-cycle op, go IDLE->DONE and assert out_valid on the cycle after acceptance (latency 1).
REQ-021 SHALL, on MUL/MULU/DIV/DIVU, go IDLE->BUSY, iterate one bit per cycle with a counter running WIDTH..1, and enter DONE after exactly WIDTH BUSY cycles, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-022 SHALL ignore in_valid while in BUSY or DONE.
REQ-023 SHALL assert out_valid only in DONE and hold result, hi and the flags stable until out_ready=1.
REQ-024 SHALL go DONE->IDLE on out_ready; in_ready rises the next cycle and there is no same-cycle accept.
REQ-025 SHALL, for MUL/MULU, form the full 2*WIDTH-bit product with {hi,result}=product; MUL is signed x signed, MULU unsigned.
REQ-026 SHALL, for DIVU, set result=a/b and hi=a%b.
REQ-027 SHALL, for DIV, truncate the quotient toward zero and give the remainder the sign of a.
REQ-028 SHALL, for DIV of most-negative by -1, give result=most-negative, hi=0 and overflow=1.
REQ-029 SHALL, when b=0 on DIV/DIVU, still take WIDTH+1 cycles and give result=all ones, hi=a, div_zero=1.
REQ-030 SHALL set div_zero=0 for all other cases.
REQ-031 SHALL compute zero=(result==0) for every op; hi is not included.
REQ-032 SHALL set overflow for ADD on signed overflow (operands same sign, result sign differs).
REQ-033 SHALL set overflow for SUB when the operand signs differ and the result sign differs from a.
REQ-034 SHALL set overflow=0 for all ops except ADD, SUB and the DIV case in REQ-028.
REQ-035 SHALL zero-extend the SLT/SLTU 1-bit result to WIDTH.

Reset
REQ-036 SHALL, while rst_n=0, force IDLE and clear the counter, result, hi, out_valid, zero, overflow and div_zero to 0, with in_ready=1 from the first cycle after release.
REQ-037 SHALL, on rst_n low mid-BUSY or mid-DONE, abort immediately and not deliver the pending result.

Verification
REQ-038 SHALL cover: ADD a=0x7FFFFFFF, b=1 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0.
REQ-039 SHALL cover: SUB a=5, b=5 with out_ready held low 3 cycles -> result=0, zero=1, out_valid held 4 cycles, in_ready low throughout.
REQ-040 SHALL cover: MUL a=0xFFFFFFFF (-1), b=2 -> out_valid at cycle 33 after accept; hi=0xFFFFFFFF, result=0xFFFFFFFE; MULU with the same operands -> hi=1, result=0xFFFFFFFE.
REQ-041 SHALL cover: DIV a=-7, b=2 -> result=-3, hi=-1; DIVU a=7, b=0 -> result=0xFFFFFFFF, hi=7, div_zero=1, latency 33.
REQ-042 SHALL cover: SRA a=0x24 (amount 4), b=0x80000000 -> result=0xF8000000.
REQ-043 SHALL cover: rst_n pulsed low at BUSY cycle 10 of a DIV -> out_valid never rises for it, in_ready=1 after release, and a following AND 0xF0 & 0x3C returns 0x30.
